// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: turns the ray-marcher pixel stream into linear bank writes
// and rotates three frame banks so the display only ever reads a finished frame.
module frame_buffer_writer #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 4,
  parameter int ADDR_BITS      = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic                  display_vsync_in,
  output logic [ADDR_BITS-1:0]  wr_addr_out,
  output logic [COLOR_BITS-1:0] wr_data_out,
  output logic                  wr_en_out,
  output logic [1:0]            wr_bank_out,
  output logic [1:0]            display_bank_out,
  output logic                  frame_done_out,
  output logic                  frame_dropped_out,
  output logic                  oob_error_out
);

  // One extra bit so the limits compare correctly even when they
  // equal 2**H_BITS / 2**V_BITS.
  localparam logic [H_BITS:0] H_LIM =
    (H_BITS+1)'(DISPLAY_WIDTH);
  localparam logic [V_BITS:0] V_LIM =
    (V_BITS+1)'(DISPLAY_HEIGHT);
  localparam logic [ADDR_BITS-1:0] STRIDE =
    ADDR_BITS'(DISPLAY_WIDTH);

  logic                  nf_q;
  logic                  frame_edge;

  logic [H_BITS-1:0]     s1_h;
  logic [COLOR_BITS-1:0] s1_color;
  logic                  s1_valid;
  logic                  s1_done;
  logic [1:0]            s1_tag;
  logic                  s1_in_range;
  logic [ADDR_BITS-1:0]  s1_row_base;

  logic [1:0] w_bank, d_bank, p_bank;
  logic       pv;
  logic [1:0] w_nx, d_nx, p_nx;
  logic       pv_nx, done_nx, drop_nx;

  assign frame_edge       = new_frame_in & ~nf_q;
  assign display_bank_out = d_bank;

  // Stage 1: capture the pixel, tag it with the current write bank,
  // and precompute range check and row base address.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      nf_q        <= 1'b0;
      s1_h        <= '0;
      s1_color    <= '0;
      s1_valid    <= 1'b0;
      s1_done     <= 1'b0;
      s1_tag      <= 2'd0;
      s1_in_range <= 1'b0;
      s1_row_base <= '0;
    end else begin
      nf_q        <= new_frame_in;
      s1_h        <= hcount_in;
      s1_color    <= color_in;
      s1_valid    <= valid_in;
      s1_done     <= frame_edge;
      s1_tag      <= w_bank;
      s1_in_range <= ({1'b0, hcount_in} < H_LIM) &&
                     ({1'b0, vcount_in} < V_LIM);
      s1_row_base <= ADDR_BITS'(vcount_in) * STRIDE;
    end
  end

  // Stage 2: issue the write and latch the sticky out-of-range flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_addr_out   <= '0;
      wr_data_out   <= '0;
      wr_en_out     <= 1'b0;
      wr_bank_out   <= 2'd0;
      oob_error_out <= 1'b0;
    end else begin
      wr_addr_out <= s1_row_base + ADDR_BITS'(s1_h);
      wr_data_out <= s1_color;
      wr_en_out   <= s1_valid & s1_in_range;
      wr_bank_out <= s1_tag;
      if (s1_valid && !s1_in_range)
        oob_error_out <= 1'b1;
    end
  end

  // Bank rotation: completion commits first, then vsync may hand
  // the (possibly just created) pending frame to the display.
  always_comb begin
    w_nx    = w_bank;
    d_nx    = d_bank;
    p_nx    = p_bank;
    pv_nx   = pv;
    done_nx = 1'b0;
    drop_nx = 1'b0;
    if (s1_done) begin
      done_nx = 1'b1;
      p_nx    = w_bank;
      if (pv) begin
        drop_nx = 1'b1;
        w_nx    = p_bank;
      end else begin
        pv_nx = 1'b1;
        w_nx  = 2'd3 - w_bank - d_bank;
      end
    end
    if (display_vsync_in && pv_nx) begin
      d_nx  = p_nx;
      pv_nx = 1'b0;
    end
  end

  // Bank state registers and completion pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      w_bank            <= 2'd0;
      d_bank            <= 2'd1;
      p_bank            <= 2'd2;
      pv                <= 1'b0;
      frame_done_out    <= 1'b0;
      frame_dropped_out <= 1'b0;
    end else begin
      w_bank            <= w_nx;
      d_bank            <= d_nx;
      p_bank            <= p_nx;
      pv                <= pv_nx;
      frame_done_out    <= done_nx;
      frame_dropped_out <= drop_nx;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed stimulus with a write/event scoreboard
// and a decoupled monitor for frame_buffer_writer.
module tb_frame_buffer_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  hcount;
  logic [7:0]  vcount;
  logic [3:0]  color;
  logic        valid;
  logic        new_frame;
  logic        vsync;
  logic [16:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [1:0]  disp_bank;
  logic        frame_done;
  logic        frame_dropped;
  logic        oob;

  frame_buffer_writer dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .color_in          (color),
    .valid_in          (valid),
    .new_frame_in      (new_frame),
    .display_vsync_in  (vsync),
    .wr_addr_out       (wr_addr),
    .wr_data_out       (wr_data),
    .wr_en_out         (wr_en),
    .wr_bank_out       (wr_bank),
    .display_bank_out  (disp_bank),
    .frame_done_out    (frame_done),
    .frame_dropped_out (frame_dropped),
    .oob_error_out     (oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
    int bank;
  } wr_t;

  typedef struct {
    int cyc;
    int dropped;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input int c,
                     input int addr, input int bank, input bit wr);
    hcount = 9'(h);
    vcount = 8'(v);
    color  = 4'(c);
    valid  = 1'b1;
    if (wr) wq.push_back('{cyc + 2, addr, c, bank});
    step();
    valid = 1'b0;
  endtask

  task automatic ev(input int dropped);
    eq.push_back('{cyc + 2, dropped});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  // Monitor: every write or frame pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_unexpected: addr %0d bank %0d cycle %0d",
                 wr_addr, wr_bank, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        checks++;
        if (e.cyc != cyc || e.addr != int'(wr_addr) ||
            e.data != int'(wr_data) || e.bank != int'(wr_bank)) begin
          errors++;
          $display("FAIL write: got cyc %0d addr %0d data %0d bank %0d expected cyc %0d addr %0d data %0d bank %0d",
                   cyc, wr_addr, wr_data, wr_bank,
                   e.cyc, e.addr, e.data, e.bank);
        end
      end
    end
    if (frame_done || frame_dropped) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL event_unexpected: done %0d dropped %0d cycle %0d",
                 frame_done, frame_dropped, cyc);
      end else begin
        ev_t e;
        e = eq.pop_front();
        checks++;
        if (e.cyc != cyc || frame_done != 1'b1 ||
            e.dropped != int'(frame_dropped)) begin
          errors++;
          $display("FAIL event: got cyc %0d done %0d dropped %0d expected cyc %0d done 1 dropped %0d",
                   cyc, frame_done, frame_dropped, e.cyc, e.dropped);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    hcount    = '0;
    vcount    = '0;
    color     = '0;
    valid     = 1'b0;
    new_frame = 1'b0;
    vsync     = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_disp_bank", disp_bank, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_dropped", frame_dropped, 0);
    chk("rst_oob", oob, 0);
    step();

    pix(5, 2, 9, 645, 0, 1);
    pix(319, 239, 3, 76799, 0, 1);
    pix(0, 0, 15, 0, 0, 1);
    pix(320, 0, 1, 0, 0, 0);
    pix(0, 240, 1, 0, 0, 0);
    repeat (3) step();
    chk("oob_set", oob, 1);
    repeat (4) step();
    chk("oob_held", oob, 1);

    new_frame = 1'b1;
    ev(0);
    pix(1, 1, 2, 321, 0, 1);
    pix(3, 0, 5, 3, 0, 1);
    pix(4, 0, 6, 4, 2, 1);
    repeat (3) step();
    chk("disp_before_vsync", disp_bank, 1);
    new_frame = 1'b0;
    pulse_vsync();
    chk("disp_after_vsync", disp_bank, 0);
    pix(6, 0, 7, 6, 2, 1);
    repeat (3) step();

    do_reset();
    chk("rst2_disp_bank", disp_bank, 1);
    chk("rst2_oob", oob, 0);
    new_frame = 1'b1;
    ev(0);
    step();
    new_frame = 1'b0;
    step();
    new_frame = 1'b1;
    ev(1);
    step();
    new_frame = 1'b0;
    repeat (2) step();
    pix(7, 0, 8, 7, 0, 1);
    chk("drop_disp_kept", disp_bank, 1);
    pulse_vsync();
    chk("drop_disp_pending", disp_bank, 2);
    repeat (3) step();

    do_reset();
    new_frame = 1'b1;
    ev(0);
    step();
    new_frame = 1'b0;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    chk("same_cycle_disp", disp_bank, 0);
    pix(8, 0, 9, 8, 2, 1);
    pulse_vsync();
    chk("same_cycle_pv_clear", disp_bank, 0);
    repeat (3) step();

    new_frame = 1'b1;
    pix(9, 0, 1, 9, 0, 0);
    rst = 1'b1;
    new_frame = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_wr_en", wr_en, 0);
    repeat (3) step();
    chk("midrst_disp", disp_bank, 1);
    chk("midrst_oob", oob, 0);
    chk("midrst_done", frame_done, 0);
    pix(10, 0, 2, 10, 0, 1);
    pulse_vsync();
    chk("midrst_pv_clear", disp_bank, 1);
    repeat (5) step();

    chk("writes_left", wq.size(), 0);
    chk("events_left", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
